mem_align_unit: RTL

- Multi-cycle load/store alignment unit between the MEM-stage pipeline register and the data memory bus.
- Generalises the load data extender: handles byte, half and word loads and stores, sign or zero extension, and byte-enable generation for any bus width.
- Optionally splits accesses that cross a bus word into two bus transactions and merges the results.
- Talks to the pipeline through a valid/ready request port and a one-cycle response pulse. Talks to memory through a req/ack handshake with arbitrary ack latency.

---
 rtl/mem_align_pkg.sv | 40 ++++
 rtl/mem_align_ext.sv | 32 +++
 rtl/mem_align_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_align_pkg.sv
// Shared types and op decode helpers for the load/store alignment unit.
package mem_align_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Access size in bytes (1, 2 or 4).
  function automatic logic [2:0] op_size(input op_e op);
    case (op)
      OP_LW, OP_SW:         return 3'd4;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd1;
    endcase
  endfunction

  function automatic logic op_is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word loads sign-extend too, which matters once DATA_W is 64.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/mem_align_ext.sv
// Sign/zero extension of right-justified merged load bytes to full width.
module mem_align_ext
  import mem_align_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] ext_data_c
);

  localparam int unsigned BYTES = DATA_W / 8;

  logic fill;

  // Keep the low size bytes, replicate the fill bit over the rest.
  always_comb begin
    ext_data_c = '0;
    fill       = 1'b0;
    case (size)
      3'd1:    fill = raw[7];
      3'd2:    fill = raw[15];
      default: fill = raw[31];
    endcase
    fill = fill & is_signed;
    for (int i = 0; i < BYTES; i++) begin
      ext_data_c[i*8 +: 8] = (4'(i) < 4'(size)) ? raw[i*8 +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: lane shifting, byte enables, split crossing
// accesses into two bus transactions and merge/extend load results.
module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ALLOW_UNALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CW    = OFF_W + 2;

  state_e            state, state_d;
  op_e               op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cross_q, cross_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              req_ready_d, resp_valid_d, resp_err_d, busy_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [BYTES-1:0]  mem_be_d;
  logic [DATA_W-1:0] mem_wdata_d;

  op_e                 op_in;
  logic [2:0]          size_in;
  logic [OFF_W-1:0]    off_in;
  logic                misal_in, cross_in, accept;
  logic [OFF_W-1:0]    cur_off;
  logic [2:0]          cur_size;
  logic [DATA_W-1:0]   cur_wdata;
  logic [2*BYTES-1:0]  be_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [2*DATA_W-1:0] merged, merged_sh;
  logic [DATA_W-1:0]   raw_c, ext_c;

  // Decode the incoming request and build both halves of the lane layout.
  always_comb begin
    op_in     = op_e'(req_op);
    size_in   = op_size(op_in);
    off_in    = req_addr[OFF_W-1:0];
    misal_in  = |(req_addr[1:0] & 2'(size_in - 3'd1));
    cross_in  = (CW'(off_in) + CW'(size_in)) > CW'(BYTES);
    accept    = req_valid && req_ready;
    cur_off   = (state == ST_IDLE) ? off_in    : off_q;
    cur_size  = (state == ST_IDLE) ? size_in   : size_q;
    cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
    be_wide   = (((2*BYTES)'(1) << cur_size) - (2*BYTES)'(1)) << cur_off;
    wdata_wide = (2*DATA_W)'(cur_wdata) << {cur_off, 3'b000};
    merged    = (state == ST_ACC2) ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
    merged_sh = merged >> {off_q, 3'b000};
    raw_c     = merged_sh[DATA_W-1:0];
  end

  mem_align_ext #(.DATA_W(DATA_W)) u_ext (
    .raw        (raw_c),
    .size       (size_q),
    .is_signed  (op_is_signed(op_q)),
    .ext_data_c (ext_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state;
    op_d         = op_q;
    off_d        = off_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    cross_d      = cross_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_be_d     = mem_be;
    mem_wdata_d  = mem_wdata;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          off_d   = off_in;
          size_d  = size_in;
          wdata_d = req_wdata;
          cross_d = cross_in;
          if (misal_in && !ALLOW_UNALIGNED) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d     = ST_ACC1;
            mem_req_d   = 1'b1;
            mem_we_d    = op_is_store(op_in);
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_be_d    = be_wide[BYTES-1:0];
            mem_wdata_d = wdata_wide[DATA_W-1:0];
          end
        end
      end
      ST_ACC1, ST_ACC2: begin
        if (mem_req && mem_ack) begin
          lo_d = mem_rdata;
          if ((state == ST_ACC1) && cross_q) begin
            state_d     = ST_ACC2;
            mem_addr_d  = mem_addr + ADDR_W'(BYTES);
            mem_be_d    = be_wide[2*BYTES-1:BYTES];
            mem_wdata_d = wdata_wide[2*DATA_W-1:DATA_W];
          end else begin
            state_d      = ST_RESP;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_be_d     = '0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = op_is_store(op_q) ? '0 : ext_c;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        resp_err_d  = 1'b0;
        resp_data_d = '0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_LW;
      off_q      <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      cross_q    <= 1'b0;
      lo_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      cross_q    <= cross_d;
      lo_q       <= lo_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      busy       <= busy_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule
